// File: rtl/fano_pkg.sv
// rtl/fano_pkg.sv - shared Fano link constants: code masks, rate encoding, FSM states
package fano_pkg;

    localparam int K        = 89;
    localparam int TAIL_LEN = 88;

    // Parity tap masks; bit k taps the encoder bit k steps in the past.
    localparam logic [K-1:0] MASK_1_2 = 89'hD354E3267;
    localparam logic [K-1:0] MASK_3_4 = 89'h87AFC51E7688DDEE;
    localparam logic [K-1:0] MASK_7_8 = 89'o77663166177600720153763372136;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'd0,
        RATE_3_4  = 2'd1,
        RATE_7_8  = 2'd2,
        RATE_RSVD = 2'd3
    } code_rate_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } enc_state_t;

    // The reserved code falls back to rate 1/2.
    function automatic logic [K-1:0] rate_to_mask(input code_rate_t rate);
        case (rate)
            RATE_3_4: return MASK_3_4;
            RATE_7_8: return MASK_7_8;
            default:  return MASK_1_2;
        endcase
    endfunction

endpackage

// File: rtl/fano_parity_xor.sv
// rtl/fano_parity_xor.sv - masked XOR reduction of an 89-bit code register
// Ports: state (code register incl. newest bit at [0]), mask (tap mask), parity (XOR of tapped bits).
module fano_parity_xor
    import fano_pkg::*;
(
    input  logic [K-1:0] state,
    input  logic [K-1:0] mask,
    output logic         parity
);

    assign parity = ^(state & mask);

endmodule

// File: rtl/fano_conv_encoder.sv
// rtl/fano_conv_encoder.sv - streaming convolutional encoder, one {systematic, parity} symbol per info bit
// Ports: clk, reset_n (async, active low); input beat i_vld/i_data/i_eof with o_rdy; frame config
//        i_code_rate/i_diff_en sampled on the first beat; output symbol o_vld/o_sym/o_last with i_rdy;
//        o_busy high while a frame is in progress.
// Build option: FANO_ENC_TAIL_EN adds the 88-symbol zero tail after each frame.
module fano_conv_encoder
    import fano_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_code_rate,
    input  logic       i_diff_en,
    input  logic       i_vld,
    input  logic       i_data,
    input  logic       i_eof,
    output logic       o_rdy,
    output logic       o_vld,
    output logic [1:0] o_sym,
    output logic       o_last,
    input  logic       i_rdy,
    output logic       o_busy
);

    enc_state_t   state;
    logic [K-1:0] s_reg;
    logic [K-1:0] mask_reg;
    logic         d_reg;
    logic         diff_reg;
`ifdef FANO_ENC_TAIL_EN
    localparam logic [6:0] TAIL_LAST = 7'(TAIL_LEN - 1);
    logic [6:0]   tail_cnt;
`endif

    logic         out_adv;
    logic         in_fire;
    logic         emit;
    logic         in_idle;
    logic [K-1:0] eff_mask;
    logic [K-1:0] s_base;
    logic [K-1:0] s_next;
    logic         d_base;
    logic         diff_use;
    logic         b;
    logic         parity;

    assign out_adv = !o_vld || i_rdy;
    assign o_rdy   = reset_n && (state != S_TAIL) && out_adv;
    assign in_fire = i_vld && o_rdy;
    assign emit    = in_fire || ((state == S_TAIL) && out_adv);
    assign o_busy  = (state != S_IDLE);
    assign in_idle = (state == S_IDLE);

    // The first beat of a frame uses the live configuration and a zeroed history,
    // so the frame does not depend on what the previous frame left behind.
    always_comb begin
        eff_mask = in_idle ? rate_to_mask(code_rate_t'(i_code_rate)) : mask_reg;
        s_base   = in_idle ? '0 : s_reg;
        d_base   = in_idle ? 1'b0 : d_reg;
        diff_use = in_idle ? i_diff_en : diff_reg;
        b        = 1'b0;
        if (state != S_TAIL) begin
            b = i_data ^ (diff_use & d_base);
        end
        s_next   = {s_base[K-2:0], b};
    end

    fano_parity_xor u_parity (
        .state  (s_next),
        .mask   (eff_mask),
        .parity (parity)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            s_reg    <= '0;
            mask_reg <= MASK_1_2;
            d_reg    <= 1'b0;
            diff_reg <= 1'b0;
            o_vld    <= 1'b0;
            o_sym    <= 2'b00;
            o_last   <= 1'b0;
`ifdef FANO_ENC_TAIL_EN
            tail_cnt <= '0;
`endif
        end else if (out_adv) begin
            o_vld  <= emit;
            o_last <= 1'b0;
            if (emit) begin
                o_sym <= {b, parity};
                s_reg <= s_next;
            end
            case (state)
                S_IDLE, S_DATA: begin
                    if (in_fire) begin
                        d_reg <= b;
                        if (in_idle) begin
                            mask_reg <= eff_mask;
                            diff_reg <= i_diff_en;
                        end
                        if (i_eof) begin
`ifdef FANO_ENC_TAIL_EN
                            state    <= S_TAIL;
                            tail_cnt <= '0;
`else
                            state    <= S_IDLE;
                            o_last   <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_TAIL: begin
`ifdef FANO_ENC_TAIL_EN
                    tail_cnt <= tail_cnt + 7'd1;
                    if (tail_cnt == TAIL_LAST) begin
                        o_last <= 1'b1;
                        state  <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fano_conv_encoder.sv
// tb/tb_fano_conv_encoder.sv - randomized scoreboard bench for fano_conv_encoder
module tb_fano_conv_encoder;

`ifdef FANO_ENC_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [1:0] i_code_rate;
    logic       i_diff_en;
    logic       i_vld;
    logic       i_data;
    logic       i_eof;
    logic       o_rdy;
    logic       o_vld;
    logic [1:0] o_sym;
    logic       o_last;
    logic       i_rdy;
    logic       o_busy;

    fano_conv_encoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_code_rate (i_code_rate),
        .i_diff_en   (i_diff_en),
        .i_vld       (i_vld),
        .i_data      (i_data),
        .i_eof       (i_eof),
        .o_rdy       (o_rdy),
        .o_vld       (o_vld),
        .o_sym       (o_sym),
        .o_last      (o_last),
        .i_rdy       (i_rdy),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    bit         hold_prev = 0;
    logic [2:0] held;
    bit         busy_pending = 0;
    bit         busy_exp;
    int         stall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [88:0] mask_of(input logic [1:0] r);
        case (r)
            2'd1:    return 89'h87AFC51E7688DDEE;
            2'd2:    return 89'o77663166177600720153763372136;
            default: return 89'hD354E3267;
        endcase
    endfunction

    // Reference: differential pre-coding, optional zero tail, then parity as a
    // convolution sum over the encoded bit sequence.
    task automatic model_frame(input bit bits[$], input logic [1:0] rate, input bit diff);
        logic [88:0] m;
        bit          u[$];
        bit          d;
        bit          p;
        m = mask_of(rate);
        d = 1'b0;
        foreach (bits[i]) begin
            u.push_back(diff ? (bits[i] ^ d) : bits[i]);
            d = u[u.size()-1];
        end
        if (TAIL_EN) begin
            for (int i = 0; i < 88; i++) u.push_back(1'b0);
        end
        for (int n = 0; n < u.size(); n++) begin
            p = 1'b0;
            for (int k = 0; k <= n && k < 89; k++) p ^= m[k] & u[n-k];
            exp_q.push_back({u[n], p, n == u.size() - 1});
        end
    endtask

    task automatic monitor();
        logic [2:0] e;
        if (hold_prev) begin
            check("hold_vld", 32'(o_vld), 32'd1);
            check("hold_sym_last", 32'({o_sym, o_last}), 32'(held));
        end
        if (o_vld && !i_rdy) check("bp_rdy", 32'(o_rdy), 32'd0);
        if (busy_pending) begin
            check("busy_frame", 32'(o_busy), 32'(busy_exp));
            busy_pending = 0;
        end
        if (o_vld && i_rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_symbol", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sym", 32'(o_sym), 32'(e[2:1]));
                check("last", 32'(o_last), 32'(e[0]));
            end
        end
        hold_prev = o_vld && !i_rdy;
        held      = {o_sym, o_last};
    endtask

    task automatic cycle(input bit vld, input bit data, input bit eof, input logic [1:0] rate,
                         input bit diff, input int rdy_pct, output bit acc);
        @(posedge clk);
        #1;
        i_vld       = vld;
        i_data      = data;
        i_eof       = eof;
        i_code_rate = rate;
        i_diff_en   = diff;
        if (stall_cnt > 0) begin
            i_rdy = 1'b0;
            stall_cnt--;
        end else begin
            i_rdy = ($urandom_range(99) < rdy_pct);
        end
        @(negedge clk);
        acc = vld && o_rdy;
        monitor();
    endtask

    task automatic send_frame(input bit bits[$], input logic [1:0] rate, input bit diff,
                              input int vld_pct, input int rdy_pct, input bit scramble,
                              input int stall_at);
        int         idx;
        int         guard;
        bit         started;
        bit         stalled;
        bit         v;
        bit         acc;
        logic [1:0] r;
        bit         dd;
        model_frame(bits, rate, diff);
        idx = 0; guard = 0; started = 0; stalled = 0;
        while (idx < bits.size()) begin
            v  = ($urandom_range(99) < vld_pct);
            r  = (started && scramble) ? 2'($urandom_range(3)) : rate;
            dd = (started && scramble) ? 1'($urandom_range(1)) : diff;
            if (started && !stalled && idx == stall_at) begin
                stall_cnt = 5;
                stalled   = 1;
            end
            cycle(v, bits[idx], idx == bits.size() - 1, r, dd, rdy_pct, acc);
            if (acc) begin
                if (!started) begin
                    started      = 1;
                    busy_pending = 1;
                    busy_exp     = !(bits.size() == 1 && !TAIL_EN);
                end
                idx++;
            end
            guard++;
            if (guard > 5000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic drain(input int rdy_pct);
        int guard;
        bit acc;
        guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, rdy_pct, acc);
            guard++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 100, acc);
        check("busy_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        bit q[$];
        bit acc;
        int len;
        reset_n = 1'b0; i_vld = 1'b0; i_data = 1'b0; i_eof = 1'b0;
        i_code_rate = 2'd0; i_diff_en = 1'b0; i_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(o_rdy), 32'd0);
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_sym", 32'(o_sym), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        reset_n = 1'b1;

        // Impulse responses at rate 1/2 and 3/4.
        q = '{1'b1};
        send_frame(q, 2'd0, 1'b0, 100, 100, 1'b0, -1);
        drain(100);
        send_frame(q, 2'd1, 1'b0, 100, 100, 1'b0, -1);
        drain(100);

        // Differential encoding.
        q = '{1'b1, 1'b1, 1'b0};
        send_frame(q, 2'd0, 1'b1, 100, 100, 1'b0, -1);
        drain(100);

        // Five-cycle downstream stall in the middle of the data phase.
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(1'($urandom_range(1)));
        send_frame(q, 2'd2, 1'b0, 100, 100, 1'b0, 8);
        drain(100);

        // Configuration wiggling mid-frame, back-to-back frames of different rates.
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(1'($urandom_range(1)));
        send_frame(q, 2'd0, 1'b0, 100, 100, 1'b1, -1);
        send_frame(q, 2'd1, 1'b1, 100, 100, 1'b1, -1);
        drain(100);

        // Reserved rate code and random traffic with gaps on both sides.
        q = '{1'b1, 1'b0, 1'b1};
        send_frame(q, 2'd3, 1'b0, 80, 80, 1'b1, -1);
        drain(80);
        for (int f = 0; f < 6; f++) begin
            q.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) q.push_back(1'($urandom_range(1)));
            send_frame(q, 2'($urandom_range(3)), 1'($urandom_range(1)), 70, 70, 1'b1,
                       $urandom_range(1, 30));
        end
        drain(70);

        // Reset in the middle of a frame (tail phase when the tail is built in).
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(1'($urandom_range(1)));
        send_frame(q, 2'd1, 1'b0, 100, 100, 1'b0, -1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 100, acc);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_vld", 32'(o_vld), 32'd0);
        check("midrst_rdy", 32'(o_rdy), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        hold_prev = 0;
        busy_pending = 0;
        i_vld = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        q = '{1'b1};
        send_frame(q, 2'd0, 1'b0, 100, 100, 1'b0, -1);
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fano_conv_encoder.md
# fano_conv_encoder

Transmit-side streaming convolutional encoder for the Fano link. It produces the coded symbol stream that the decoder's branch re-encoder reproduces. Info bits enter one per beat and are optionally differentially encoded. Each bit is shifted into an 89-bit code register, and one symbol {systematic, parity} is emitted per bit, using the same per-rate parity masks as the decoder. Each frame is terminated with an 88-bit zero tail so the decoder ends in the zero state. The block sits between the framer and the modulator mapper.

## Interface
- No parameters; constants come from the shared package.
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_code_rate  in  2  2'd0 1/2, 2'd1 3/4, 2'd2 7/8, 2'd3 treated as 1/2; sampled at frame start only
- i_diff_en  in  1  differential encoding enable; sampled at frame start only
- i_vld  in  1  input beat valid
- i_data  in  1  info bit
- i_eof  in  1  marks last info bit of frame; qualified by i_vld
- o_rdy  out  1  input accept; beat transfers when i_vld && o_rdy
- o_vld  out  1  output symbol valid
- o_sym  out  2  {systematic bit, parity bit}
- o_last  out  1  final symbol of frame; qualified by o_vld
- i_rdy  in  1  downstream accept; symbol transfers when o_vld && i_rdy
- o_busy  out  1  frame in progress (state != IDLE)

## Operation
- State vector s[88:0]: s[0] = current encoder bit, s[k] = bit k steps earlier. Shift is s <= {s[87:0], b}.
- parity = XOR-reduce(s_next & mask), where s_next = {s[87:0], b}. Systematic = b.
- Differential encoding, when the frame's latched diff flag is set: b = i_data ^ d, then d <= b. Otherwise b = i_data. d is cleared at frame start.
- FSM IDLE:
  - Output register free → o_rdy = 1.
  - On the first accepted beat:
    - latch mask from i_code_rate and the diff flag from i_diff_en;
    - treat s and d as zero for this beat;
    - emit its symbol;
    - go to DATA, or go straight to TAIL if i_eof is set.
- DATA:
  - Each accepted beat shifts and emits one symbol.
  - A beat with i_eof → TAIL, tail counter = 0.
- TAIL:
  - o_rdy = 0.
  - Whenever the output register is free, shift b = 0, bypassing differential encoding, and emit a symbol.
  - Counter increments per emitted symbol.
  - After the 88th tail symbol (counter 87), which carries o_last = 1 → IDLE.
- Rate or diff changes while o_busy = 1 have no effect until the next frame.
- Output register advances when !o_vld || i_rdy. While o_vld && !i_rdy, o_sym and o_last hold stable and nothing shifts.
- Any i_vld beat with i_eof in IDLE is a one-bit frame (1 data symbol + 88 tail symbols).

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - FSM = IDLE; s, d, mask register (= 1/2 mask) and tail counter cleared;
  - o_vld = 0, o_sym = 2'b00, o_last = 0, o_busy = 0;
  - o_rdy = 0 while reset_n is low.
- Latency: accepted beat at edge N → its symbol valid after edge N; o_vld is high in cycle N+1.
- Throughput: 1 symbol/clk with i_rdy held high; the tail adds exactly 88 cycles.
- o_rdy = reset_n && state != TAIL && (!o_vld || i_rdy). This is combinational from registers and i_rdy; there is no path from i_vld.
- Reset asserted mid-frame: partial frame and pending symbol are discarded. No o_last is generated.

## Configuration
- FANO_ENC_TAIL_EN defined: TAIL state and counter are present, with behaviour as above.
- Not defined:
  - i_eof → IDLE directly; the eof symbol carries o_last = 1.
  - No zero tail is emitted. s is still cleared at the next frame start.

## Structure
- Package fano_pkg:
  - MASK_1_2 = 89'hD354E3267;
  - MASK_3_4 = 89'h87AFC51E7688DDEE;
  - MASK_7_8 = 89'o77663166177600720153763372136;
  - K = 89, TAIL_LEN = 88;
  - code_rate_t enum;
  - function rate_to_mask().
- The decoder's re-encoder also uses fano_pkg.
- Sub-module fano_parity_xor: combinational AND with the mask, then an 89-bit XOR reduction. It is reusable by the decoder side.

## Test plan
- Rate 1/2, diff off, tail on, single beat i_data = 1 with i_eof:
  - 89 symbols total;
  - symbol k (k = 0..88) = {k==0, MASK_1_2[k]}: first symbol 2'b11, last symbol 2'b00 with o_last = 1;
  - o_busy drops the cycle after.
- Rate 3/4 impulse, same stimulus: first symbol 2'b10 (MASK_3_4[0] = 0); the parity sequence equals the MASK_3_4 bits.
- Diff on, rate 1/2, bits 1,1,0,eof: systematic bits 1,0,0, then the tail.
- Backpressure: i_rdy low for 5 cycles mid-DATA:
  - o_sym and o_last stable;
  - o_rdy = 0;
  - no symbol lost or duplicated against the golden model.
- Change i_code_rate from 0 to 1 mid-frame: the current frame uses MASK_1_2; the next frame uses MASK_3_4.
- Reset asserted during TAIL:
  - o_vld = 0 immediately;
  - the next frame's impulse matches the first scenario.
- Build without the macro: single-bit frame yields one symbol 2'b11 with o_last = 1.
